// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator datapath.
// Contents: command op-codes (3-bit) and the sequencer state type.
package acc_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_LOAD = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_SHR  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_NOP  = 3'b110;  // 3'b111 is also NOP

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_MUL
  } state_t;

endpackage

// File: rtl/acc_addsub.sv
// Combinational WIDTH-bit adder/subtractor.
// Ports:
//   x, y  : operands
//   sub   : 0 -> x+y, 1 -> x-y
//   sum   : result modulo 2^WIDTH
//   cout  : carry-out for add, borrow (x<y unsigned) for subtract
//   ovf   : two's-complement overflow
module acc_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] y_eff;
  logic             c_raw;

  always_comb begin
    y_eff         = y ^ {WIDTH{sub}};
    {c_raw, sum}  = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub};
    // Raw carry of x + ~y + 1 is the inverse of borrow.
    cout          = c_raw ^ sub;
    ovf           = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
  end

endmodule

// File: rtl/acc_datapath_seq.sv
// Accumulator datapath with a start/done command handshake.
// Single-cycle ops: ADD, SUB, LOAD, NOP (and zero-length shifts).
// Multi-cycle ops: SHL/SHR by shamt bits, shift-add MUL (WIDTH cycles).
// Ports:
//   CLK, Clr          : clock (rising edge), async active-low reset
//   start, op         : command request and op-code, sampled when idle
//   v0, v1            : operand selects (left: a/t, right: b/c)
//   shamt, lshl       : shift count, serial fill bit for SHL
//   a, b, c           : operand sources
//   t                 : accumulator
//   busy, done        : multi-cycle in progress, completion pulse
//   carry, zero, ovf  : status flags of the last completed op
module acc_datapath_seq
  import acc_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               CLK,
  input  logic               Clr,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic               v0,
  input  logic               v1,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               lshl,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  output logic [WIDTH-1:0]   t,
  output logic               busy,
  output logic               done,
  output logic               carry,
  output logic               zero,
  output logic               ovf
);

  state_t               state;
  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [SHAMT_W-1:0]   cnt;
  logic                 shr;

  logic [WIDTH-1:0]     lop, rop;
  logic                 in_mul;
  logic [WIDTH-1:0]     as_x, as_y, as_sum;
  logic                 as_sub, as_cout, as_ovf;

  logic [WIDTH-1:0]     sh_t;
  logic                 sh_out;
  logic [WIDTH-1:0]     acc_hi;
  logic                 acc_c;
  logic [WIDTH-1:0]     mul_hi_n, mul_t_n;

  // Operand muxes
  always_comb begin
    lop = v0 ? a : t;
    rop = v1 ? b : c;
  end

  // The adder serves ADD/SUB while idle and the partial-product add in MUL.
  always_comb begin
    in_mul = (state == ST_MUL);
    as_x   = in_mul ? hi    : lop;
    as_y   = in_mul ? mcand : rop;
    as_sub = !in_mul && (op == OP_SUB);
  end

  acc_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x    (as_x),
    .y    (as_y),
    .sub  (as_sub),
    .sum  (as_sum),
    .cout (as_cout),
    .ovf  (as_ovf)
  );

  // One shift step and one multiply step.
  // MUL adds mcand into the high half and shifts {carry,hi,t} right, so after
  // WIDTH steps {hi,t} holds the full product (equivalent to adding mcand at
  // weight 2^i into {hi,t}).
  always_comb begin
    sh_t     = shr ? {1'b0, t[WIDTH-1:1]} : {t[WIDTH-2:0], lshl};
    sh_out   = shr ? t[0] : t[WIDTH-1];
    acc_hi   = mplier[0] ? as_sum  : hi;
    acc_c    = mplier[0] ? as_cout : 1'b0;
    mul_hi_n = {acc_c, acc_hi[WIDTH-1:1]};
    mul_t_n  = {acc_hi[0], t[WIDTH-1:1]};
  end

  always_ff @(posedge CLK or negedge Clr) begin
    if (!Clr) begin
      state  <= ST_IDLE;
      t      <= '0;
      hi     <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      shr    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_ADD, OP_SUB: begin
                t     <= as_sum;
                carry <= as_cout;
                ovf   <= as_ovf;
                zero  <= (as_sum == '0);
                done  <= 1'b1;
              end
              OP_LOAD: begin
                t     <= lop;
                carry <= 1'b0;
                ovf   <= 1'b0;
                zero  <= (lop == '0);
                done  <= 1'b1;
              end
              OP_SHL, OP_SHR: begin
                if (shamt == '0) begin
                  carry <= 1'b0;
                  ovf   <= 1'b0;
                  zero  <= (t == '0);
                  done  <= 1'b1;
                end else begin
                  cnt   <= shamt;
                  shr   <= (op == OP_SHR);
                  busy  <= 1'b1;
                  state <= ST_SHIFT;
                end
              end
              OP_MUL: begin
                mcand  <= lop;
                mplier <= rop;
                t      <= '0;
                hi     <= '0;
                cnt    <= '0;
                busy   <= 1'b1;
                state  <= ST_MUL;
              end
              OP_NOP: done <= 1'b1;
              default: done <= 1'b1;
            endcase
          end
        end

        ST_SHIFT: begin
          t <= sh_t;
          if (cnt == SHAMT_W'(1)) begin
            carry <= sh_out;
            ovf   <= 1'b0;
            zero  <= (sh_t == '0);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - SHAMT_W'(1);
          end
        end

        ST_MUL: begin
          t      <= mul_t_n;
          hi     <= mul_hi_n;
          mplier <= mplier >> 1;
          if (cnt == SHAMT_W'(WIDTH - 1)) begin
            carry <= 1'b0;
            ovf   <= (mul_hi_n != '0);
            zero  <= (mul_t_n == '0);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + SHAMT_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_datapath_seq.sv
module tb_acc_datapath_seq;

  localparam int W  = 8;
  localparam int SW = 3;
  localparam int M  = (1 << W) - 1;

  logic          CLK = 1'b0;
  logic          Clr;
  logic          start;
  logic [2:0]    op;
  logic          v0, v1;
  logic [SW-1:0] shamt;
  logic          lshl;
  logic [W-1:0]  a, b, c;
  logic [W-1:0]  t;
  logic          busy, done, carry, zero, ovf;

  int tests = 0;
  int fails = 0;

  // Reference architectural state
  int mt = 0;
  bit mc = 0, mz = 0, mo = 0;

  acc_datapath_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .CLK   (CLK),
    .Clr   (Clr),
    .start (start),
    .op    (op),
    .v0    (v0),
    .v1    (v1),
    .shamt (shamt),
    .lshl  (lshl),
    .a     (a),
    .b     (b),
    .c     (c),
    .t     (t),
    .busy  (busy),
    .done  (done),
    .carry (carry),
    .zero  (zero),
    .ovf   (ovf)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
  endfunction

  // Applies one command to the reference state; returns cycles from the
  // accept edge to the completion edge.
  function automatic int model(input logic [2:0] o, input bit v0i, input bit v1i,
                               input int sh, input bit fill,
                               input int ai, input int bi, input int ci);
    int l, r, s;
    l = v0i ? ai : mt;
    r = v1i ? bi : ci;
    case (o)
      3'd0: begin
        s  = l + r;
        mt = s & M;
        mc = ((s >> W) & 1) != 0;
        s  = sx(l) + sx(r);
        mo = (s > M / 2) || (s < -(M / 2) - 1);
        mz = (mt == 0);
        return 0;
      end
      3'd1: begin
        mt = (l - r) & M;
        mc = (l < r);
        s  = sx(l) - sx(r);
        mo = (s > M / 2) || (s < -(M / 2) - 1);
        mz = (mt == 0);
        return 0;
      end
      3'd2: begin
        mt = l; mc = 0; mo = 0; mz = (mt == 0);
        return 0;
      end
      3'd3, 3'd4: begin
        mo = 0;
        if (sh == 0) begin
          mc = 0; mz = (mt == 0);
          return 0;
        end
        if (o == 3'd3) begin
          mc = ((mt >> (W - sh)) & 1) != 0;
          mt = ((mt << sh) | (fill ? (1 << sh) - 1 : 0)) & M;
        end else begin
          mc = ((mt >> (sh - 1)) & 1) != 0;
          mt = mt >> sh;
        end
        mz = (mt == 0);
        return sh;
      end
      3'd5: begin
        s  = l * r;
        mt = s & M;
        mo = (s > M);
        mc = 0;
        mz = (mt == 0);
        return W;
      end
      default: return 0;
    endcase
  endfunction

  task automatic drive(input logic [2:0] o, input bit v0i, input bit v1i, input int sh,
                       input bit fill, input int ai, input int bi, input int ci);
    op = o; v0 = v0i; v1 = v1i; shamt = SW'(sh); lshl = fill;
    a = W'(ai); b = W'(bi); c = W'(ci);
  endtask

  // Issues one command, waits (bounded) for done, checks latency and results.
  task automatic do_cmd(input string tag, input logic [2:0] o, input bit v0i, input bit v1i,
                        input int sh, input bit fill, input int ai, input int bi,
                        input int ci, input bit poke);
    int exp_lat, lat;
    exp_lat = model(o, v0i, v1i, sh, fill, ai, bi, ci);
    @(negedge CLK);
    drive(o, v0i, v1i, sh, fill, ai, bi, ci);
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < W + 4) begin
      check({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
      if (poke && lat == 1) begin
        start = 1'b1; op = 3'd2; v0 = 1'b1; a = ~a;
      end
      @(posedge CLK); #1;
      start = 1'b0;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_t"}, {24'd0, t}, mt);
    check({tag, "_carry"}, {31'd0, carry}, {31'd0, mc});
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, mz});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, mo});
    @(posedge CLK); #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int l;
    Clr = 1'b0; start = 1'b0;
    drive(3'd0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0);
    #12;
    check("rst_t", {24'd0, t}, 32'd0);
    check("rst_flags", {27'd0, busy, done, carry, zero, ovf}, 32'd0);
    @(negedge CLK); Clr = 1'b1;

    // Directed walk
    do_cmd("add1",  3'd0, 1, 1, 0, 0, 1, 4, 0, 0);
    do_cmd("sub1",  3'd1, 0, 0, 0, 0, 0, 0, 2, 0);
    do_cmd("sub2",  3'd1, 0, 1, 0, 0, 0, 4, 0, 0);
    do_cmd("addov", 3'd0, 1, 1, 0, 0, 8'h7F, 1, 0, 0);
    do_cmd("load0", 3'd2, 1, 0, 0, 0, 0, 0, 0, 0);
    do_cmd("ld81",  3'd2, 1, 0, 0, 0, 8'h81, 0, 0, 0);
    do_cmd("shl3",  3'd3, 0, 0, 3, 1, 0, 0, 0, 1);
    do_cmd("shr7",  3'd4, 1, 1, 7, 0, 0, 0, 0, 0);
    do_cmd("shl0",  3'd3, 0, 0, 0, 1, 0, 0, 0, 0);
    do_cmd("mul1",  3'd5, 1, 1, 0, 0, 13, 11, 0, 1);
    do_cmd("mul2",  3'd5, 1, 1, 0, 0, 8'h20, 8'h10, 0, 0);
    do_cmd("nop",   3'd7, 1, 1, 0, 0, 9, 9, 9, 0);
    do_cmd("mulT",  3'd5, 0, 0, 0, 0, 0, 0, 8'hFF, 0);

    // Back-to-back single-cycle accepts
    @(negedge CLK);
    drive(3'd2, 1, 0, 0, 0, 8'h10, 0, 0); start = 1'b1;
    l = model(3'd2, 1, 0, 0, 0, 8'h10, 0, 0);
    @(posedge CLK); #1;
    check("b2b1_t", {24'd0, t}, mt);
    drive(3'd0, 0, 1, 0, 0, 0, 8'h05, 0);
    l = model(3'd0, 0, 1, 0, 0, 0, 8'h05, 0);
    @(posedge CLK); #1;
    start = 1'b0;
    check("b2b2_t", {24'd0, t}, mt);
    check("b2b2_done", {31'd0, done}, 32'd1);
    @(posedge CLK); #1;
    check("b2b_done_pulse", {31'd0, done}, 32'd0);

    // Asynchronous reset in the middle of a multiply
    @(negedge CLK);
    drive(3'd5, 1, 1, 0, 0, 13, 11, 0); start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    repeat (3) @(posedge CLK);
    #2 Clr = 1'b0;
    #1;
    check("mrst_t", {24'd0, t}, 32'd0);
    check("mrst_flags", {27'd0, busy, done, carry, zero, ovf}, 32'd0);
    @(negedge CLK); Clr = 1'b1;
    mt = 0; mc = 0; mz = 0; mo = 0;
    do_cmd("post_rst_add", 3'd0, 1, 1, 0, 0, 1, 4, 0, 0);

    // Randomized commands against the reference
    for (int i = 0; i < 60; i++) begin
      do_cmd("rnd", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, W - 1)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, M)),
             int'($urandom_range(0, M)), int'($urandom_range(0, M)),
             1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
